// File: rtl/uart_pkg.sv
// UART shared definitions: frame-level constants, FSM state encoding, baud divisor helper.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
//
// Contents:
//   uart_state_t       transmit FSM states (IDLE, LOAD, START, DATA, STOP)
//   START_BIT/STOP_BIT line levels for the framing bits
//   DATA_BITS          payload bits per frame
//   calc_clks_per_bit  clock cycles per line bit (truncating division)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Truncating divide; the result must be at least 2 for the baud counter
    // to have a meaningful count range.
    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with registered read data.
// Latency: dout valid the cycle after the edge that samples rd_en=1 with empty=0.
// Backpressure: writes dropped while full, reads ignored while empty.
//
// Ports:
//   core_clk, arst_n     clock, async active-low reset
//   wr_en, din, full     write port
//   rd_en, dout, empty   read port
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;
    assign dout   = r_dout;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge core_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_dout <= r_mem[r_rptr];
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Latency: tick is combinational, high during the last cycle of each bit period.
// Backpressure: none; clear has priority over enable.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   clear           restart the period at count 0
//   enable          advance the count
//   tick            one-cycle pulse at count CLKS_PER_BIT-1
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    assign tick = enable && (r_count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a FIFO read port and serialises them as 8N1 UART frames.
// Latency: start bit begins 2 edges after the pop request; frame is 10 bit periods.
// Backpressure: pops only when idle and non-empty; FIFO holds bytes while a frame is on the line.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   fifo_empty, fifo_dout         upstream FIFO status and read data
//   fifo_rd_en                    upstream FIFO pop (combinational)
//   serial_out                    TX line, idles high
//   busy                          high from the pop until the stop bit ends
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_serial;
    logic        r_busy;

    logic        w_tick;
    logic        w_baud_clear;
    logic        w_baud_en;
    logic        w_dout_unused;

    // Only the low byte is serialised; upper entry bits are don't-care.
    assign w_dout_unused = ^fifo_dout;

    // Gated by rst so no pop can be issued while the block is held in reset.
    assign fifo_rd_en = rst && (r_state == ST_IDLE) && !fifo_empty;

    assign serial_out = r_serial;
    assign busy       = r_busy;

    assign w_baud_clear = (r_state == ST_LOAD);
    assign w_baud_en    = (r_state == ST_START) || (r_state == ST_DATA) ||
                          (r_state == ST_STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_baud_clear),
        .enable (w_baud_en),
        .tick   (w_tick)
    );

    // serial_out is registered alongside the state, so each transition also
    // loads the line level of the bit that the new state drives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_serial  <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_serial <= STOP_BIT;
                    if (!fifo_empty) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // FIFO read data is valid this cycle (registered read port).
                    r_shift   <= fifo_dout[7:0];
                    r_bit_idx <= '0;
                    r_serial  <= START_BIT;
                    r_state   <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_serial <= r_shift[0];
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == LAST_BIT) begin
                            r_serial <= STOP_BIT;
                            r_state  <= ST_STOP;
                        end else begin
                            // Next bit is the one about to be shifted into position 0.
                            r_serial  <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_serial <= STOP_BIT;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_serial <= STOP_BIT;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx driven through a real 8-deep FIFO.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int CPB        = 10;
    localparam int FRAME      = 10 * CPB;
    localparam int PERIOD     = FRAME + 2;
    localparam int DW         = 10;
    localparam int DEPTH      = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_arst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          serial_out;
    logic          busy;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
        .core_clk (clk),
        .arst_n   (fifo_arst_n),
        .wr_en    (wr_en),
        .din      (din),
        .full     (fifo_full),
        .rd_en    (fifo_rd_en),
        .dout     (fifo_dout),
        .empty    (fifo_empty)
    );

    fifo_uart_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy)
    );

    // Reference model: bytes expected on the line, in order.
    logic [7:0] exp_q[$];

    // Ideal line waveform of one frame, one entry per clock cycle.
    function automatic logic [FRAME-1:0] model_wave(input logic [7:0] b);
        logic [FRAME-1:0] w;
        int k;
        for (int t = 0; t < FRAME; t++) begin
            k = t / CPB;
            if (k == 0)      w[t] = 1'b0;
            else if (k == 9) w[t] = 1'b1;
            else             w[t] = b[k-1];
        end
        return w;
    endfunction

    // Line monitor: samples on the falling clock edge and records frames.
    int               cyc = 0;
    int               rd_cnt = 0;
    int               viol_cnt = 0;
    int               rd_cyc[$];
    int               busy_fall[$];
    logic [7:0]       dec_byte[$];
    int               dec_start[$];
    logic [FRAME-1:0] dec_wave[$];
    bit               m_in_frame = 1'b0;
    int               m_t0 = 0;
    logic [FRAME-1:0] m_wave = '0;
    logic [7:0]       m_b;
    logic             m_line_prev = 1'b1;
    logic             m_busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd_en === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc.push_back(cyc);
            if (fifo_empty === 1'b1) viol_cnt = viol_cnt + 1;
        end
        if (m_busy_prev === 1'b1 && busy === 1'b0) busy_fall.push_back(cyc);
        m_busy_prev = busy;
        if (rst === 1'b0) begin
            m_in_frame = 1'b0;
        end else if (!m_in_frame) begin
            if (m_line_prev === 1'b1 && serial_out === 1'b0) begin
                m_in_frame = 1'b1;
                m_t0 = cyc;
                m_wave = '0;
                m_wave[0] = serial_out;
            end
        end else begin
            m_wave[cyc - m_t0] = serial_out;
            if (cyc - m_t0 == FRAME - 1) begin
                m_in_frame = 1'b0;
                for (int i = 0; i < 8; i++) m_b[i] = m_wave[(i + 1) * CPB + CPB / 2];
                dec_byte.push_back(m_b);
                dec_start.push_back(m_t0);
                dec_wave.push_back(m_wave);
            end
        end
        m_line_prev = serial_out;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fifo_write(input logic [7:0] b);
        din = {2'($urandom_range(3, 0)), b};
        wr_en = 1'b1;
        exp_q.push_back(b);
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (dec_byte.size() < target && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_start(output int k);
        k = 0;
        while (serial_out !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
    endtask

    task automatic test_reset();
        int bad_s = 0, bad_b = 0, bad_r = 0;
        int r0;
        #2;
        rst = 1'b0;
        fifo_arst_n = 1'b0;
        #1;
        n_chk++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL reset_serial: got %b want 1", serial_out); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        tick(2);
        rst = 1'b1;
        fifo_arst_n = 1'b1;
        r0 = rd_cnt;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (serial_out !== 1'b1) bad_s++;
            if (busy !== 1'b0) bad_b++;
            if (fifo_rd_en !== 1'b0) bad_r++;
        end
        n_chk++; if (bad_s != 0) begin n_err++; $display("FAIL idle_serial: %0d cycles not high, want 0", bad_s); end
        n_chk++; if (bad_b != 0) begin n_err++; $display("FAIL idle_busy: %0d cycles busy, want 0", bad_b); end
        n_chk++; if (bad_r != 0) begin n_err++; $display("FAIL idle_rd_en: %0d cycles rd_en, want 0", bad_r); end
        n_chk++; if (rd_cnt - r0 != 0) begin n_err++; $display("FAIL idle_pops: got %0d want 0", rd_cnt - r0); end
    endtask

    task automatic test_single();
        int n0 = dec_byte.size();
        int r0 = rd_cnt;
        int rc0 = rd_cyc.size();
        int bf0 = busy_fall.size();
        logic [FRAME-1:0] w;
        logic [9:0] mids;
        logic [9:0] want_mids = 10'b11_0100_1010;
        fifo_write(8'hA5);
        wait_frames(n0 + 1, 3 * PERIOD);
        tick(5);
        n_chk++; if (dec_byte.size() != n0 + 1) begin n_err++; $display("FAIL single_frames: got %0d want %0d", dec_byte.size(), n0 + 1); end
        n_chk++; if (rd_cnt - r0 != 1) begin n_err++; $display("FAIL single_pops: got %0d want 1", rd_cnt - r0); end
        if (dec_byte.size() > n0 && rd_cyc.size() > rc0 && busy_fall.size() > bf0) begin
            w = dec_wave[n0];
            for (int k = 0; k < 10; k++) mids[k] = w[k * CPB + CPB / 2];
            n_chk++; if (dec_start[n0] - rd_cyc[rc0] != 2) begin n_err++; $display("FAIL single_start_lat: got %0d want 2", dec_start[n0] - rd_cyc[rc0]); end
            n_chk++; if (mids !== want_mids) begin n_err++; $display("FAIL single_midbits: got %b want %b", mids, want_mids); end
            n_chk++; if (dec_byte[n0] !== exp_q[n0]) begin n_err++; $display("FAIL single_byte: got %h want %h", dec_byte[n0], exp_q[n0]); end
            n_chk++; if (w !== model_wave(exp_q[n0])) begin n_err++; $display("FAIL single_wave: got %h want %h", w, model_wave(exp_q[n0])); end
            n_chk++; if (busy_fall[bf0] - rd_cyc[rc0] != PERIOD) begin n_err++; $display("FAIL single_busy_span: got %0d want %0d", busy_fall[bf0] - rd_cyc[rc0], PERIOD); end
        end
        n_chk++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_back_to_back();
        int n0 = dec_byte.size();
        int r0 = rd_cnt;
        fifo_write(8'h00);
        fifo_write(8'hFF);
        fifo_write(8'h3C);
        wait_frames(n0 + 3, 4 * PERIOD);
        tick(20);
        n_chk++; if (dec_byte.size() != n0 + 3) begin n_err++; $display("FAIL b2b_frames: got %0d want %0d", dec_byte.size(), n0 + 3); end
        n_chk++; if (rd_cnt - r0 != 3) begin n_err++; $display("FAIL b2b_pops: got %0d want 3", rd_cnt - r0); end
        if (dec_byte.size() >= n0 + 3) begin
            for (int i = n0; i < n0 + 3; i++) begin
                n_chk++; if (dec_byte[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_byte[%0d]: got %h want %h", i - n0, dec_byte[i], exp_q[i]); end
                n_chk++; if (dec_wave[i] !== model_wave(exp_q[i])) begin n_err++; $display("FAIL b2b_wave[%0d]: got %h want %h", i - n0, dec_wave[i], model_wave(exp_q[i])); end
            end
            for (int i = n0 + 1; i < n0 + 3; i++) begin
                n_chk++; if (dec_start[i] - dec_start[i-1] != PERIOD) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i - n0, dec_start[i] - dec_start[i-1], PERIOD); end
            end
        end
    endtask

    task automatic test_full();
        int n0 = dec_byte.size();
        int r0 = rd_cnt;
        int v0 = viol_cnt;
        int k = 0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h10 + i));
        n_chk++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", fifo_full); end
        n_chk++; if (rd_cnt != r0) begin n_err++; $display("FAIL full_no_pop_in_reset: got %0d want 0", rd_cnt - r0); end
        rst = 1'b1;
        #1;
        while (fifo_rd_en !== 1'b1 && k < 10) begin tick(1); k++; end
        n_chk++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL full_first_pop: rd_en %b want 1", fifo_rd_en); end
        k = 0;
        while (fifo_full === 1'b1 && k < 10) begin tick(1); k++; end
        n_chk++; if (fifo_full !== 1'b0 || k > 3) begin n_err++; $display("FAIL full_drop: full %b after %0d cycles, want 0 within 3", fifo_full, k); end
        wait_frames(n0 + 8, 9 * PERIOD);
        tick(20);
        n_chk++; if (dec_byte.size() != n0 + 8) begin n_err++; $display("FAIL full_frames: got %0d want %0d", dec_byte.size(), n0 + 8); end
        if (dec_byte.size() >= n0 + 8) begin
            for (int i = n0; i < n0 + 8; i++) begin
                n_chk++; if (dec_byte[i] !== exp_q[i]) begin n_err++; $display("FAIL full_byte[%0d]: got %h want %h", i - n0, dec_byte[i], exp_q[i]); end
            end
        end
        n_chk++; if (rd_cnt - r0 != 8) begin n_err++; $display("FAIL full_pops: got %0d want 8", rd_cnt - r0); end
        n_chk++; if (viol_cnt - v0 != 0) begin n_err++; $display("FAIL full_rd_when_empty: got %0d want 0", viol_cnt - v0); end
    endtask

    task automatic test_reset_mid();
        int n0 = dec_byte.size();
        int k;
        fifo_write(8'h81);
        fifo_write(8'h42);
        wait_start(k);
        n_chk++; if (k >= 20) begin n_err++; $display("FAIL rmid_start: no start bit after %0d cycles", k); end
        tick(45);
        n_chk++; if (serial_out !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_bit3: serial %b busy %b, want 0 1", serial_out, busy); end
        rst = 1'b0;
        #1;
        n_chk++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL rmid_serial: got %b want 1", serial_out); end
        n_chk++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL rmid_busy_rd: busy %b rd_en %b, want 0 0", busy, fifo_rd_en); end
        exp_q.delete(n0);
        tick(3);
        rst = 1'b1;
        wait_frames(n0 + 1, 3 * PERIOD);
        tick(2 * PERIOD);
        n_chk++; if (dec_byte.size() != n0 + 1) begin n_err++; $display("FAIL rmid_frames: got %0d want %0d", dec_byte.size(), n0 + 1); end
        if (dec_byte.size() > n0) begin
            n_chk++; if (dec_byte[n0] !== exp_q[n0]) begin n_err++; $display("FAIL rmid_byte: got %h want %h", dec_byte[n0], exp_q[n0]); end
            n_chk++; if (dec_wave[n0] !== model_wave(exp_q[n0])) begin n_err++; $display("FAIL rmid_wave: got %h want %h", dec_wave[n0], model_wave(exp_q[n0])); end
        end
        n_chk++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_write_during_tx();
        int n0 = dec_byte.size();
        int k;
        fifo_write(8'hAA);
        wait_start(k);
        tick(25);
        fifo_write(8'h55);
        n_chk++; if (fifo_rd_en !== 1'b0 || fifo_empty !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL wdt_hold: rd_en %b empty %b busy %b, want 0 0 1", fifo_rd_en, fifo_empty, busy);
        end
        wait_frames(n0 + 2, 3 * PERIOD);
        tick(10);
        n_chk++; if (dec_byte.size() != n0 + 2) begin n_err++; $display("FAIL wdt_frames: got %0d want %0d", dec_byte.size(), n0 + 2); end
        if (dec_byte.size() >= n0 + 2) begin
            for (int i = n0; i < n0 + 2; i++) begin
                n_chk++; if (dec_wave[i] !== model_wave(exp_q[i])) begin n_err++; $display("FAIL wdt_wave[%0d]: got %h want %h", i - n0, dec_wave[i], model_wave(exp_q[i])); end
            end
            n_chk++; if (dec_start[n0+1] - dec_start[n0] != PERIOD) begin n_err++; $display("FAIL wdt_period: got %0d want %0d", dec_start[n0+1] - dec_start[n0], PERIOD); end
        end
    endtask

    task automatic test_random();
        int n0 = dec_byte.size();
        int nb = 12;
        int gap;
        int k;
        for (int i = 0; i < nb; i++) begin
            gap = ($urandom_range(1, 0) == 1) ? $urandom_range(4, 0) : $urandom_range(250, 50);
            tick(gap);
            k = 0;
            while (fifo_full === 1'b1 && k < 3 * PERIOD) begin tick(1); k++; end
            fifo_write(8'($urandom));
        end
        wait_frames(n0 + nb, (nb + 2) * PERIOD);
        tick(20);
        n_chk++; if (dec_byte.size() != n0 + nb) begin n_err++; $display("FAIL rand_frames: got %0d want %0d", dec_byte.size(), n0 + nb); end
        if (dec_byte.size() >= n0 + nb) begin
            for (int i = n0; i < n0 + nb; i++) begin
                n_chk++; if (dec_wave[i] !== model_wave(exp_q[i])) begin n_err++; $display("FAIL rand_frame[%0d]: byte %h want %h", i - n0, dec_byte[i], exp_q[i]); end
                if (i > n0) begin
                    n_chk++; if (dec_start[i] - dec_start[i-1] < PERIOD) begin n_err++; $display("FAIL rand_spacing[%0d]: got %0d want >= %0d", i - n0, dec_start[i] - dec_start[i-1], PERIOD); end
                end
            end
        end
        n_chk++; if (viol_cnt != 0) begin n_err++; $display("FAIL rd_when_empty_total: got %0d want 0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_write_during_tx();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
